// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock FIFO with FWFT/standard read, levels and sticky error flags
module fifo_sync_fwft #(
  parameter int DATA_LEN   = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_LEN   = $clog2(DEPTH),
  parameter int AFULL_THR  = DEPTH - 4,
  parameter int AEMPTY_THR = 4,
  parameter int FWFT       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                err_clr_i,
  input  logic                wen_i,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic                ren_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic                valid_o,
  output logic                full,
  output logic                empty,
  output logic                afull,
  output logic                aempty,
  output logic [ADDR_LEN:0]   level_o,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [ADDR_LEN:0] DEPTH_V  = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] AFULL_V  = (ADDR_LEN+1)'(AFULL_THR);
  localparam logic [ADDR_LEN:0] AEMPTY_V = (ADDR_LEN+1)'(AEMPTY_THR);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [ADDR_LEN:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
  logic [ADDR_LEN-1:0] wr_addr, rd_addr;
  logic                wacc, racc, ovf_set, unf_set;

  assign wacc    = wen_i & ~full & ~clr_i;
  assign racc    = ren_i & ~empty & ~clr_i;
  assign ovf_set = wen_i & full & ~clr_i;
  assign unf_set = ren_i & empty & ~clr_i;
  assign wr_addr = wr_ptr[ADDR_LEN-1:0];
  assign rd_addr = rd_ptr[ADDR_LEN-1:0];

  // The wrap bit makes the pointer difference the exact fill level, 0..DEPTH.
  always_comb begin
    wr_nxt = wr_ptr + {{ADDR_LEN{1'b0}}, wacc};
    rd_nxt = rd_ptr + {{ADDR_LEN{1'b0}}, racc};
    if (clr_i) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
    level_nxt = wr_nxt - rd_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_o   <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      level_o   <= level_nxt;
      full      <= (level_nxt == DEPTH_V);
      empty     <= (level_nxt == '0);
      afull     <= (level_nxt >= AFULL_V);
      aempty    <= (level_nxt <= AEMPTY_V);
      overflow  <= ovf_set | (overflow & ~err_clr_i);
      underflow <= unf_set | (underflow & ~err_clr_i);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wacc) mem[wr_addr] <= data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as the FIFO is non-empty; zero otherwise.
      assign data_o  = empty ? '0 : mem[rd_addr];
      assign valid_o = ~empty;
    end else begin : g_std
      logic [DATA_LEN-1:0] data_q;
      logic                valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= racc;
          if (racc) data_q <= mem[rd_addr];
        end
      end

      assign data_o  = data_q;
      assign valid_o = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - self-checking bench for fifo_sync_fwft in both read modes
module tb_fifo_sync_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr, eclr, wen, ren;
  logic [31:0] din, dout;
  logic        valid, full, empty, afull, aempty, ovf, unf;
  logic [3:0]  level;

  logic        clr0, eclr0, wen0, ren0;
  logic [31:0] din0, dout0;
  logic        valid0, full0, empty0, afull0, aempty0, ovf0, unf0;
  logic [3:0]  level0;

  fifo_sync_fwft #(.DATA_LEN(32), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(1), .FWFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .err_clr_i(eclr), .wen_i(wen), .data_i(din),
    .ren_i(ren), .data_o(dout), .valid_o(valid), .full(full), .empty(empty), .afull(afull),
    .aempty(aempty), .level_o(level), .overflow(ovf), .underflow(unf));

  fifo_sync_fwft #(.DATA_LEN(32), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(1), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr0), .err_clr_i(eclr0), .wen_i(wen0), .data_i(din0),
    .ren_i(ren0), .data_o(dout0), .valid_o(valid0), .full(full0), .empty(empty0), .afull(afull0),
    .aempty(aempty0), .level_o(level0), .overflow(ovf0), .underflow(unf0));

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of words plus two sticky bits, updated from the
  // inputs in force for this cycle, then compared after the clock edge.
  task automatic tick();
    int  n;
    logic so, su;
    n  = q.size();
    so = wen && (n == 8);
    su = ren && (n == 0);
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (clr) begin
      q.delete();
      m_ovf = m_ovf && !eclr;
      m_unf = m_unf && !eclr;
    end else begin
      if (ren && n != 0) void'(q.pop_front());
      if (wen && n != 8) q.push_back(din);
      m_ovf = so || (m_ovf && !eclr);
      m_unf = su || (m_unf && !eclr);
    end
    @(posedge clk);
    #1;
    n = q.size();
    chk("level", 32'(level), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 8));
    chk("afull", 32'(afull), 32'(n >= 6));
    chk("aempty", 32'(aempty), 32'(n <= 1));
    chk("valid", 32'(valid), 32'(n != 0));
    chk("data", dout, (n != 0) ? q[0] : 32'h0);
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; eclr = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    clr0 = 1'b0; eclr0 = 1'b0; wen0 = 1'b0; ren0 = 1'b0; din0 = '0;
    #2;
    tick();
    tick();
    chk("rst_valid0", 32'(valid0), 32'h0);
    chk("rst_data0", dout0, 32'h0);
    chk("rst_empty0", 32'(empty0), 32'h1);
    rst_n = 1'b1;

    // Fill to full with 0xA0..0xA7
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; din = 32'hA0 + 32'(i);
      tick();
      chk("s1_level", 32'(level), 32'(i + 1));
      chk("s1_aempty", 32'(aempty), 32'(i == 0));
      chk("s1_afull", 32'(afull), 32'(i >= 5));
      chk("s1_full", 32'(full), 32'(i == 7));
      chk("s1_ovf", 32'(ovf), 32'h0);
    end

    // Write while full is dropped and flagged; drain in order
    din = 32'hDEAD;
    tick();
    wen = 1'b0;
    chk("s2_ovf", 32'(ovf), 32'h1);
    chk("s2_level", 32'(level), 32'h8);
    for (int i = 0; i < 8; i++) begin
      chk("s2_head", dout, 32'hA0 + 32'(i));
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    chk("s2_empty", 32'(empty), 32'h1);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    chk("s2_errclr", 32'(ovf), 32'h0);

    // Level 3, then simultaneous write+read across the 7->0 wrap
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; din = 32'hB0 + 32'(i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("s3_head", dout, (i < 3) ? 32'hB0 + 32'(i) : 32'hC0 + 32'(i - 3));
      wen = 1'b1; ren = 1'b1; din = 32'hC0 + 32'(i);
      tick();
      chk("s3_level", 32'(level), 32'h3);
    end
    wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s3_tail", dout, 32'hC2 + 32'(i));
      tick();
    end
    ren = 1'b0;

    // Read+write on empty: read refused, write accepted
    wen = 1'b1; ren = 1'b1; din = 32'h44;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("s4_unf", 32'(unf), 32'h1);
    chk("s4_level", 32'(level), 32'h1);
    chk("s4_data", dout, 32'h44);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    chk("s4_unf_clr", 32'(unf), 32'h0);

    // Flush with a concurrent write; sticky flag survives
    ren = 1'b1;
    tick();
    tick();
    ren = 1'b0;
    chk("s5_unf_set", 32'(unf), 32'h1);
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; din = 32'hD0 + 32'(i);
      tick();
    end
    clr = 1'b1; din = 32'hEE;
    tick();
    clr = 1'b0; wen = 1'b0;
    chk("s5_level", 32'(level), 32'h0);
    chk("s5_empty", 32'(empty), 32'h1);
    chk("s5_valid", 32'(valid), 32'h0);
    chk("s5_unf", 32'(unf), 32'h1);
    chk("s5_ovf", 32'(ovf), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wen  = ($urandom_range(0, 99) < 55);
      ren  = ($urandom_range(0, 99) < 50);
      din  = $urandom;
      clr  = ($urandom_range(0, 31) == 0);
      eclr = ($urandom_range(0, 15) == 0);
      tick();
    end
    wen = 1'b0; ren = 1'b0; clr = 1'b0; eclr = 1'b0;

    // Standard read mode on the second instance
    wen0 = 1'b1; din0 = 32'h11;
    tick();
    din0 = 32'h22;
    tick();
    wen0 = 1'b0;
    chk("s6_valid_idle", 32'(valid0), 32'h0);
    chk("s6_level", 32'(level0), 32'h2);
    ren0 = 1'b1;
    tick();
    ren0 = 1'b0;
    chk("s6_data", dout0, 32'h11);
    chk("s6_valid", 32'(valid0), 32'h1);
    chk("s6_level1", 32'(level0), 32'h1);
    tick();
    chk("s6_valid_drop", 32'(valid0), 32'h0);
    chk("s6_hold", dout0, 32'h11);
    tick();
    chk("s6_hold2", dout0, 32'h11);

    // Reset mid-stream
    wen0 = 1'b1; din0 = 32'h33; wen = 1'b1; din = 32'h55;
    rst_n = 1'b0;
    tick();
    wen0 = 1'b0; wen = 1'b0;
    chk("s6_rst_level", 32'(level0), 32'h0);
    chk("s6_rst_empty", 32'(empty0), 32'h1);
    chk("s6_rst_full", 32'(full0), 32'h0);
    chk("s6_rst_afull", 32'(afull0), 32'h0);
    chk("s6_rst_aempty", 32'(aempty0), 32'h1);
    chk("s6_rst_valid", 32'(valid0), 32'h0);
    chk("s6_rst_data", dout0, 32'h0);
    chk("s6_rst_ovf", 32'(ovf0), 32'h0);
    chk("s6_rst_unf", 32'(unf0), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
